// File: rtl/csr_counter_pkg.sv
// ============================================================================
//  Module      : csr_counter_pkg
//  Description : CSR addresses and modify opcodes for the performance counters.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package csr_counter_pkg;

    localparam logic [11:0] c_csr_mcycle    = 12'hB00;
    localparam logic [11:0] c_csr_minstret  = 12'hB02;
    localparam logic [11:0] c_csr_mcycleh   = 12'hB80;
    localparam logic [11:0] c_csr_minstreth = 12'hB82;
    localparam logic [11:0] c_csr_cycle     = 12'hC00;
    localparam logic [11:0] c_csr_time      = 12'hC01;
    localparam logic [11:0] c_csr_instret   = 12'hC02;
    localparam logic [11:0] c_csr_cycleh    = 12'hC80;
    localparam logic [11:0] c_csr_timeh     = 12'hC81;
    localparam logic [11:0] c_csr_instreth  = 12'hC82;

    typedef enum logic [2:0] {
        MOD_NONE  = 3'd0,
        MOD_WRITE = 3'd1,
        MOD_SET   = 3'd2,
        MOD_CLEAR = 3'd3
    } modify_op_e;

    function automatic logic csr_is_mapped(input logic [11:0] a);
        logic hit;
        hit = 1'b0;
        case (a)
            c_csr_mcycle, c_csr_minstret, c_csr_mcycleh, c_csr_minstreth,
            c_csr_cycle, c_csr_time, c_csr_instret,
            c_csr_cycleh, c_csr_timeh, c_csr_instreth: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Codes 4-7 are treated as no-op.
    function automatic logic csr_is_modify(input logic [2:0] op);
        return (op == MOD_WRITE) || (op == MOD_SET) || (op == MOD_CLEAR);
    endfunction

    function automatic logic [31:0] csr_apply(input logic [2:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] operand);
        logic [31:0] res;
        case (op)
            MOD_WRITE: res = operand;
            MOD_SET:   res = old_val | operand;
            MOD_CLEAR: res = old_val & ~operand;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/csr_counter64.sv
// ============================================================================
//  Module      : csr_counter64
//  Description : Free-running counter with per-half 32-bit load; a load wins
//                over the increment for the whole counter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module csr_counter64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_wr_lo,
    input  logic             i_wr_hi,
    input  logic [31:0]      i_wdata,
    output logic [WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) begin
                r_value[31:0] <= i_wdata;
            end
            if (i_wr_hi) begin
                r_value[WIDTH-1:32] <= i_wdata[WIDTH-33:0];
            end
        end else if (i_inc) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign o_value = r_value;

endmodule

`default_nettype wire

// File: rtl/csr_counter.sv
// ============================================================================
//  Module      : csr_counter
//  Description : mcycle/minstret (and user aliases) CSR slave with one-cycle
//                read latency and write/set/clear modify on the B-range.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module csr_counter
    import csr_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retired,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid
);

    logic [CNT_WIDTH-1:0] w_cycle;
    logic [CNT_WIDTH-1:0] w_instret;
    logic [31:0]          w_cycle_lo;
    logic [31:0]          w_cycle_hi;
    logic [31:0]          w_instret_lo;
    logic [31:0]          w_instret_hi;

    logic [31:0]          w_sel;
    logic                 w_hit;
    logic [31:0]          w_old;
    logic [31:0]          w_new;
    logic                 w_mod_en;
    logic                 w_cyc_wr_lo;
    logic                 w_cyc_wr_hi;
    logic                 w_ins_wr_lo;
    logic                 w_ins_wr_hi;

    logic [11:0]          r_addr;
    logic                 r_hit;
    logic [31:0]          r_rdata;

    // High halves are zero-extended when the counter is narrower than 64 bits.
    assign w_cycle_lo   = w_cycle[31:0];
    assign w_cycle_hi   = 32'(w_cycle >> 32);
    assign w_instret_lo = w_instret[31:0];
    assign w_instret_hi = 32'(w_instret >> 32);

    assign w_hit = csr_is_mapped(addr);

    always_comb begin
        w_sel = '0;
        case (addr)
            c_csr_mcycle, c_csr_cycle, c_csr_time:     w_sel = w_cycle_lo;
            c_csr_mcycleh, c_csr_cycleh, c_csr_timeh:  w_sel = w_cycle_hi;
            c_csr_minstret, c_csr_instret:             w_sel = w_instret_lo;
            c_csr_minstreth, c_csr_instreth:           w_sel = w_instret_hi;
            default:                                   w_sel = '0;
        endcase
    end

    // The modify acts on the address captured with the previous request.
    always_comb begin
        w_old = '0;
        case (r_addr)
            c_csr_mcycle:    w_old = w_cycle_lo;
            c_csr_mcycleh:   w_old = w_cycle_hi;
            c_csr_minstret:  w_old = w_instret_lo;
            c_csr_minstreth: w_old = w_instret_hi;
            default:         w_old = '0;
        endcase
    end

    assign w_mod_en    = csr_is_modify(modify);
    assign w_new       = csr_apply(modify, w_old, wdata);
    assign w_cyc_wr_lo = w_mod_en && (r_addr == c_csr_mcycle);
    assign w_cyc_wr_hi = w_mod_en && (r_addr == c_csr_mcycleh);
    assign w_ins_wr_lo = w_mod_en && (r_addr == c_csr_minstret);
    assign w_ins_wr_hi = w_mod_en && (r_addr == c_csr_minstreth);

    csr_counter64 #(
        .WIDTH   (CNT_WIDTH)
    ) u_cycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_cyc_wr_lo),
        .i_wr_hi (w_cyc_wr_hi),
        .i_wdata (w_new),
        .o_value (w_cycle)
    );

    csr_counter64 #(
        .WIDTH   (CNT_WIDTH)
    ) u_instret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (retired),
        .i_wr_lo (w_ins_wr_lo),
        .i_wr_hi (w_ins_wr_hi),
        .i_wdata (w_new),
        .o_value (w_instret)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_hit   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (read) begin
                r_addr <= addr;
            end
            r_hit   <= read && w_hit;
            r_rdata <= (read && w_hit) ? w_sel : '0;
        end
    end

    assign valid = r_hit;
    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_csr_counter.sv
// ============================================================================
//  Module      : tb_csr_counter
//  Description : Directed self-checking bench for csr_counter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_csr_counter;

    logic        clk;
    logic        rst;
    logic        retired;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    int          vectors;
    int          miscompares;
    logic [63:0] m_cyc;
    logic [63:0] m_ins;
    logic [31:0] lo_keep;

    csr_counter #(
        .CNT_WIDTH (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .retired (retired),
        .read    (read),
        .modify  (modify),
        .wdata   (wdata),
        .addr    (addr),
        .rdata   (rdata),
        .valid   (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the counter model advances as an unmodified counter would.
    task automatic tick();
        logic ret;
        ret = retired;
        @(posedge clk);
        #1;
        m_cyc = m_cyc + 64'd1;
        if (ret) m_ins = m_ins + 64'd1;
    endtask

    task automatic rd(input logic [11:0] a, input logic exp_v,
                      input logic [31:0] exp_d, input string tag);
        read = 1'b1;
        addr = a;
        tick();
        read = 1'b0;
        addr = '0;
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, exp_v});
        chk({tag, "_rdata"}, rdata, exp_d);
    endtask

    task automatic mod(input logic [2:0] op, input logic [31:0] wd);
        modify = op;
        wdata  = wd;
        tick();
        modify = '0;
        wdata  = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        retired = 1'b0;
        read    = 1'b0;
        modify  = '0;
        wdata   = '0;
        addr    = '0;
        m_cyc   = '0;
        m_ins   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // Idle 10 clocks then read cycle aliases
        repeat (10) tick();
        rd(12'hC00, 1'b1, 32'd10, "cycle10");
        rd(12'hC80, 1'b1, 32'd0, "cycleh");
        rd(12'hC81, 1'b1, 32'd0, "timeh");
        rd(12'hC01, 1'b1, 32'd13, "time");

        // Seven retirements
        retired = 1'b1;
        repeat (7) tick();
        retired = 1'b0;
        rd(12'hB02, 1'b1, 32'd7, "minstret7");
        rd(12'hC02, 1'b1, 32'd7, "instret7");
        rd(12'hC82, 1'b1, 32'd0, "instreth0");

        // mcycle low write and wrap into the high half
        rd(12'hB00, 1'b1, m_cyc[31:0], "mcycle_pre");
        mod(3'd1, 32'hFFFF_FFF0);
        m_cyc = {m_cyc[63:32], 32'hFFFF_FFF0};
        rd(12'hC00, 1'b1, 32'hFFFF_FFF0, "cyc_written");
        rd(12'hB00, 1'b1, 32'hFFFF_FFF1, "cyc_count");
        repeat (20) tick();
        rd(12'hB80, 1'b1, 32'd1, "mcycleh_wrap");
        rd(12'hC00, 1'b1, 32'd7, "cyc_after_wrap");

        // mcycleh write: low half holds for that edge
        rd(12'hB80, 1'b1, 32'd1, "mcycleh_pre");
        lo_keep = m_cyc[31:0];
        mod(3'd1, 32'h0000_ABCD);
        m_cyc = {32'h0000_ABCD, lo_keep};
        rd(12'hC80, 1'b1, 32'h0000_ABCD, "cycleh_written");
        rd(12'hC00, 1'b1, 32'hA, "cyc_lo_held");

        // minstret write / set / clear, read-only alias ignored
        rd(12'hB02, 1'b1, 32'd7, "minstret_pre");
        mod(3'd1, 32'd5);
        rd(12'hB02, 1'b1, 32'd5, "minstret_w5");
        mod(3'd2, 32'h0A);
        rd(12'hB02, 1'b1, 32'h0F, "minstret_set");
        mod(3'd3, 32'h01);
        m_ins = 64'hE;
        rd(12'hC02, 1'b1, 32'h0E, "minstret_clr");
        mod(3'd1, 32'h1234);
        rd(12'hC02, 1'b1, 32'h0E, "instret_ro");
        retired = 1'b1;
        repeat (3) tick();
        retired = 1'b0;
        rd(12'hC02, 1'b1, 32'h11, "instret_counts");

        // Unmapped address: no hit, write ignored
        rd(12'h3FF, 1'b0, 32'd0, "unmapped");
        mod(3'd1, 32'hFFFF_FFFF);
        rd(12'hC00, 1'b1, m_cyc[31:0], "cyc_unaffected");
        rd(12'hC02, 1'b1, 32'h11, "ins_unaffected");

        // Write wins over retired on the same edge
        rd(12'hB02, 1'b1, 32'h11, "minstret_pre2");
        retired = 1'b1;
        mod(3'd1, 32'h100);
        retired = 1'b0;
        m_ins = 64'h100;
        rd(12'hB02, 1'b1, 32'h100, "write_beats_retire");

        // Back-to-back: new read alongside modify of the previous request
        rd(12'hB82, 1'b1, 32'd0, "minstreth_pre");
        read   = 1'b1;
        addr   = 12'hC02;
        modify = 3'd1;
        wdata  = 32'd3;
        tick();
        read   = 1'b0;
        addr   = '0;
        modify = '0;
        wdata  = '0;
        chk("b2b_valid", {31'd0, valid}, 32'd1);
        chk("b2b_rdata", rdata, 32'h100);
        rd(12'hC82, 1'b1, 32'd3, "b2b_hi_written");
        rd(12'hC02, 1'b1, 32'h100, "b2b_lo_kept");

        // Asynchronous reset pulse between clock edges
        read = 1'b1;
        addr = 12'hC00;
        tick();
        read = 1'b0;
        addr = '0;
        chk("pre_rst_valid", {31'd0, valid}, 32'd1);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        m_cyc = '0;
        m_ins = '0;
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        tick();
        rd(12'hC00, 1'b1, 32'd1, "cyc_after_rst");
        rd(12'hC80, 1'b1, 32'd0, "cych_after_rst");
        rd(12'hB02, 1'b1, 32'd0, "ins_after_rst");
        rd(12'hC82, 1'b1, 32'd0, "insh_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csr_counter.md
Name: csr_counter

Overview:
- Machine/user performance-counter CSR block for the RudolV pipeline's CSR bus.
- Holds a 64-bit cycle counter (also serves as time) and a 64-bit instructions-retired counter.
- Answers CSR reads with one-cycle latency; accepts write/set/clear modifies on the machine-mode aliases.
- Sits beside the ID CSR block; its rdata/valid are OR-combined with the other CSR slaves.

Parameters:
- CNT_WIDTH, 64, counter width; upper half is CNT_WIDTH-32 bits, and unused bits read as 0. Must be 33..64.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- retired  input  1  one instruction retired this cycle
- read  input  1  CSR access request this cycle; addr valid
- modify  input  3  modify op, applied one cycle after the request: 0 none, 1 write, 2 set bits, 3 clear bits, 4-7 none
- wdata  input  32  operand for modify; valid in the modify cycle
- addr  input  12  CSR address, sampled when read=1
- rdata  output  32  read data, one cycle after the request; 0 when valid=0
- valid  output  1  address hit, one cycle after the request

Behaviour:
- Address map:
  - mcycle B00 / mcycleh B80: cycle counter low/high, R/W.
  - minstret B02 / minstreth B82: instret counter low/high, R/W.
  - cycle C00 / cycleh C80 and time C01 / timeh C81: all read the cycle counter, read-only.
  - instret C02 / instreth C82: read-only.
- Reset (async): cycle=0, instret=0, registered addr=0, hit=0, rdata=0, valid=0.
- Cycle counter increments by 1 every clock while not in reset. Wraps from all-ones to 0.
- Instret counter increments by 1 on each clock with retired=1. Wraps likewise.
- Request cycle N, read=1:
  - Register addr and an address-hit flag at the edge ending cycle N.
  - Register rdata from the selected half of the counter value during cycle N, i.e. the value before that edge's increment.
  - In cycle N+1: valid=hit, rdata=value if hit, else 0.
  - read=0: valid=0 and rdata=0 in the next cycle.
- Modify in cycle N+1 (modify≠0) targets the address registered in cycle N.
  - Applies only to the B-range R/W addresses; ignored for C-range and unmapped addresses.
  - new = wdata (1), old|wdata (2), old&~wdata (3); old is the current half value.
  - Written half takes the new value at the edge ending cycle N+1.
  - The same counter does not increment that edge; the write wins over increment/retired.
  - Other half unchanged, no carry propagation.
  - The other counter keeps counting normally.
- Back-to-back requests: a new read may be issued in the same cycle as the modify of the previous request. The registered address is updated at the same edge the modify is applied; the modify uses the old registered address.
- High-half accesses with CNT_WIDTH<64: writes truncate, reads zero-extend.
- rst asserted mid-operation clears everything immediately. A pending modify is lost.

Decomposition:
- Shared package: CSR address constants (B00, B02, B80, B82, C00, C01, C02, C80, C81, C82) and modify op codes (NONE=0, WRITE=1, SET=2, CLEAR=3).
- One natural sub-module, csr_counter64: a 64-bit counter with increment enable, low/high half write-enable and 32-bit load data. Instantiate twice (cycle, instret).

Test Plan:
- Reset then idle 10 clocks, read C00 → valid=1 next cycle, rdata = cycle value at request (10 ± reset-release alignment, checked against a bench model); C80 and C81 return 0.
- Drive retired=1 for 7 cycles, then 0; read B02 → rdata=7. Read C02 → 7. Read C82 → 0.
- Read B00, next cycle modify=1 wdata=FFFFFFF0 → following reads show the low half counting up from FFFFFFF0. After wrap, mcycleh has incremented by 1.
- Write minstret=5, then modify=2 wdata=0A on B02, then modify=3 wdata=01 on B02 → read gives 0E. A write to C02 is ignored and the value keeps counting only on retired.
- Read unmapped 3FF → valid=0, rdata=0 next cycle. A write to it leaves both counters unaffected.
- Write issued in the same cycle as retired=1 on minstret with wdata=100 → value exactly 100 (no +1). Async rst pulse mid-count → all counters read 0 afterwards.
